// File: rtl/cunit_mc.sv
// cunit_mc: multicycle MIPS control unit.
// Moore FSM that steps each instruction through fetch, decode, execute,
// memory and writeback. It drives the datapath control lines, counts
// retired instructions and keeps a sticky illegal-opcode flag.
//
// Optional build macro: CUNIT_MEM_WAIT_EN adds the mem_rdy input.
//
// Memory handshake (only with CUNIT_MEM_WAIT_EN):
//   - The FSM presents a request (MRead or MWrite) in FETCH, MEM_RD or MEM_WR.
//   - The request stays stable until the memory answers with mem_rdy=1.
//   - The access completes on the first rising edge where mem_rdy=1.
//   - In FETCH, PCWrite and IRWrite are qualified by mem_rdy, so the PC and
//     the IR load exactly once per fetch.
//   - In MEM_WR, instr_done is qualified by mem_rdy.
//   - mem_rdy is ignored in every other state.
// Without the macro, memory answers in a single cycle (mem_rdy is treated as 1).
module cunit_mc #(
  parameter int OP_W  = 6,
  parameter int AOP_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CUNIT_MEM_WAIT_EN
  input  logic             mem_rdy,
`endif
  input  logic [OP_W-1:0]  UIn,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MRead,
  output logic             MWrite,
  output logic             IRWrite,
  output logic             MtoR,
  output logic             RegDs,
  output logic             Urw,
  output logic             ALUsrcA,
  output logic [1:0]       ALUsrcB,
  output logic [AOP_W-1:0] AOp,
  output logic [1:0]       PCSrc,
  output logic             instr_done,
  output logic             err_op,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  // State encoding (also visible on the debug output 'state')
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_R_EXEC   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_I_EXEC   = 4'd11;
  localparam logic [3:0] S_I_WB     = 4'd12;

  // Opcodes recognised in DECODE
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

  // ALU operation encodings
  localparam logic [AOP_W-1:0] AOP_ADD   = AOP_W'(0);
  localparam logic [AOP_W-1:0] AOP_SUB   = AOP_W'(1);
  localparam logic [AOP_W-1:0] AOP_FUNCT = AOP_W'(2);

  logic [3:0] state_nxt;
  logic       is_lw;
  logic       op_illegal;
  logic       rdy;

`ifdef CUNIT_MEM_WAIT_EN
  assign rdy = mem_rdy;
`else
  assign rdy = 1'b1;
`endif

  // Opcode outside the supported set; only meaningful while in DECODE
  always_comb begin
    op_illegal = 1'b1;
    case (UIn)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_illegal = 1'b0;
      default:                                       op_illegal = 1'b1;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (UIn)
          OP_RTYPE:      state_nxt = S_R_EXEC;
          OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
          OP_BEQ:        state_nxt = S_BRANCH;
          OP_J:          state_nxt = S_JUMP;
          OP_ADDI:       state_nxt = S_I_EXEC;
          default:       state_nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_nxt = is_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   state_nxt = rdy ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_nxt = S_R_WB;
      S_R_WB:     state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_I_EXEC:   state_nxt = S_I_WB;
      S_I_WB:     state_nxt = S_FETCH;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Remember in DECODE whether a memory instruction is a load; UIn is free afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 is_lw <= 1'b0;
    else if (state == S_DECODE) is_lw <= (UIn == OP_LW);
  end

  // Sticky illegal-opcode flag, set on the DECODE edge of a bad opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_op <= 1'b0;
    else if (state == S_DECODE && op_illegal)  err_op <= 1'b1;
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr_cnt <= '0;
    else if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  // Control outputs decoded from the state (mem_rdy only qualifies write strobes)
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MRead       = 1'b0;
    MWrite      = 1'b0;
    IRWrite     = 1'b0;
    MtoR        = 1'b0;
    RegDs       = 1'b0;
    Urw         = 1'b0;
    ALUsrcA     = 1'b0;
    ALUsrcB     = 2'd0;
    AOp         = AOP_ADD;
    PCSrc       = 2'd0;
    instr_done  = 1'b0;
    case (state)
      S_FETCH: begin
        MRead   = 1'b1;
        IRWrite = rdy;
        ALUsrcB = 2'd1;
        AOp     = AOP_ADD;
        PCWrite = rdy;
        PCSrc   = 2'd0;
      end
      S_DECODE: begin
        ALUsrcB = 2'd3;
        AOp     = AOP_ADD;
      end
      S_MEM_ADDR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'd2;
        AOp     = AOP_ADD;
      end
      S_MEM_RD: begin
        MRead = 1'b1;
        IorD  = 1'b1;
      end
      S_MEM_WB: begin
        Urw        = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MWrite     = 1'b1;
        IorD       = 1'b1;
        instr_done = rdy;
      end
      S_R_EXEC: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'd0;
        AOp     = AOP_FUNCT;
      end
      S_R_WB: begin
        Urw        = 1'b1;
        MtoR       = 1'b1;
        RegDs      = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUsrcA     = 1'b1;
        ALUsrcB     = 2'd0;
        AOp         = AOP_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = 2'd1;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'd2;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'd2;
        AOp     = AOP_ADD;
      end
      S_I_WB: begin
        Urw        = 1'b1;
        MtoR       = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

endmodule
